dmem_responder: RTL and testbench

- Data-memory responder on the CPU's data port. It serves the loads and stores the single-cycle CPU issues each cycle.
- Reads are combinational, so the CPU completes a load in the same cycle. Stores commit on the rising clock edge with byte, halfword or word lanes.
- Faulting accesses are suppressed and recorded in a sticky error capture register. A saturating store counter supports debug.
- Sits beside the CPU core in the top level, in place of a plain RAM.

---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-port bus between the single-cycle CPU and the data-memory responder.
// Groups the load/store request, size/extension controls, load data, the
// sticky error capture outputs, the error clear and the store counter.
//   master : CPU side (drives requests, address, store data, err_clr)
//   slave  : responder side (drives dmemout, err*, st_count)
interface dmem_responder_if;
   logic        dmemwena;
   logic        dmemrena;
   logic [31:0] aluout;
   logic [31:0] dmemdata;
   logic [1:0]  wbh;
   logic        wbh_fh;
   logic [31:0] dmemout;
   logic        err;
   logic [31:0] err_addr;
   logic [1:0]  err_code;
   logic        err_clr;
   logic [15:0] st_count;

   modport master (
      output dmemwena, dmemrena, aluout, dmemdata, wbh, wbh_fh, err_clr,
      input  dmemout, err, err_addr, err_code, st_count
   );

   modport slave (
      input  dmemwena, dmemrena, aluout, dmemdata, wbh, wbh_fh, err_clr,
      output dmemout, err, err_addr, err_code, st_count
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle CPU data port.
// Loads are combinational (zero-cycle) with byte/halfword/word selection and
// sign/zero extension; stores commit on the rising edge with lane masking.
// Faulting accesses are suppressed; the first fault is held in a sticky
// capture register. A saturating counter tallies committed stores.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset, clears array and all registers
//   bus   : dmem_responder_if.slave (requests, load data, error capture,
//           store counter)
module dmem_responder #(
   parameter int          DEPTH = 64,
   parameter int          AW    = 6,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input logic             clock,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [1:0] FLT_NONE  = 2'b00;
   localparam logic [1:0] FLT_ALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE = 2'b10;
   localparam logic [1:0] FLT_SIZE  = 2'b11;

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sx);
      return {{16{sx & h[15]}}, h};
   endfunction

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sx);
      return {{24{sx & b[7]}}, b};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic [31:0] mem [DEPTH];

   logic [31:0] off;
   logic        in_range;
   logic [AW-1:0] idx;
   logic [1:0]  lane;
   logic        misaligned;
   logic [1:0]  fault;
   logic [31:0] word_rd;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;
   logic [31:0] load_data;
   logic [3:0]  lane_mask;
   logic [31:0] wdata;
   logic        commit;
   logic        capture;

   logic        err_flag;
   logic [31:0] err_addr_reg;
   logic [1:0]  err_code_reg;
   logic [15:0] st_count_reg;

   // Address decode and fault classification
   always_comb begin
      off        = bus.aluout - BASE;
      in_range   = (off < SPAN);
      idx        = off[AW+1:2];
      lane       = bus.aluout[1:0];
      misaligned = ((bus.wbh == SZ_WORD) && (lane != 2'b00)) ||
                   ((bus.wbh == SZ_HALF) && lane[0]);
      if (bus.wbh == SZ_RSVD)
         fault = FLT_SIZE;
      else if (!in_range)
         fault = FLT_RANGE;
      else if (misaligned)
         fault = FLT_ALIGN;
      else
         fault = FLT_NONE;
   end

   // Combinational load path; old array contents are seen during a same-cycle store
   always_comb begin
      word_rd   = mem[idx];
      half_sel  = lane[1] ? word_rd[31:16] : word_rd[15:0];
      byte_sel  = word_rd[8*lane +: 8];
      load_data = 32'h0;
      if (fault == FLT_NONE) begin
         case (bus.wbh)
            SZ_WORD: load_data = word_rd;
            SZ_HALF: load_data = ext_half(half_sel, bus.wbh_fh);
            SZ_BYTE: load_data = ext_byte(byte_sel, bus.wbh_fh);
            default: load_data = 32'h0;
         endcase
      end
   end

   // Store lane selection; narrow data is replicated so each lane picks its copy
   always_comb begin
      case (bus.wbh)
         SZ_WORD: begin
            lane_mask = 4'b1111;
            wdata     = bus.dmemdata;
         end
         SZ_HALF: begin
            lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{bus.dmemdata[15:0]}};
         end
         SZ_BYTE: begin
            lane_mask = 4'b0001 << lane;
            wdata     = {4{bus.dmemdata[7:0]}};
         end
         default: begin
            lane_mask = 4'b0000;
            wdata     = 32'h0;
         end
      endcase
      commit  = bus.dmemwena && (fault == FLT_NONE);
      // A clear in the same cycle frees the capture register for the new fault
      capture = (bus.dmemwena || bus.dmemrena) && (fault != FLT_NONE) &&
                (!err_flag || bus.err_clr);
   end

   // Array write stage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < DEPTH; w++)
            mem[w] <= 32'h0;
      end else if (commit) begin
         for (int b = 0; b < 4; b++)
            if (lane_mask[b])
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // Store counter and first-fault capture stage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_count_reg <= 16'h0;
         err_flag     <= 1'b0;
         err_addr_reg <= 32'h0;
         err_code_reg <= 2'b00;
      end else begin
         if (commit)
            st_count_reg <= sat_inc(st_count_reg);
         if (capture) begin
            err_flag     <= 1'b1;
            err_addr_reg <= bus.aluout;
            err_code_reg <= fault;
         end else if (bus.err_clr) begin
            err_flag     <= 1'b0;
            err_addr_reg <= 32'h0;
            err_code_reg <= 2'b00;
         end
      end
   end

   assign bus.dmemout  = load_data;
   assign bus.err      = err_flag;
   assign bus.err_addr = err_addr_reg;
   assign bus.err_code = err_code_reg;
   assign bus.st_count = st_count_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a table of per-cycle vectors for the
// basic load/store/fault flow, then hand-written sequences for error clear,
// read-during-write, asynchronous reset, unqualified faults and saturation.
module tb_dmem_responder;

   logic clock;
   logic reset;

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH (64),
      .AW    (6),
      .BASE  (32'h0000_0000)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  wbh;
      logic        fh;
      logic [31:0] exp_out;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [13];

   int total;
   int passed;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] wbh, input logic fh);
      bus.dmemwena = we;
      bus.dmemrena = re;
      bus.aluout   = addr;
      bus.dmemdata = data;
      bus.wbh      = wbh;
      bus.wbh_fh   = fh;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      bus.err_clr = 1'b0;
   endtask

   initial begin
      total  = 0;
      passed = 0;

      //            we    re    addr          data          wbh    fh    exp_out       err   code   cnt
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        2'b00, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 16'd0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h8899_AABB, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 16'd0};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0,        2'b10, 1'b1, 32'hFFFF_FF88, 1'b0, 2'b00, 16'd1};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0,        2'b10, 1'b0, 32'h0000_0088, 1'b0, 2'b00, 16'd1};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,        2'b01, 1'b1, 32'hFFFF_AABB, 1'b0, 2'b00, 16'd1};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0005, 32'hFFFF_FF12, 2'b10, 1'b0, 32'h0000_00AA, 1'b0, 2'b00, 16'd1};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0006, 32'hABCD_3456, 2'b01, 1'b0, 32'h0000_8899, 1'b0, 2'b00, 16'd2};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,        2'b00, 1'b0, 32'h3456_12BB, 1'b0, 2'b00, 16'd3};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_FFFF, 2'b01, 1'b0, 32'h0000_0000, 1'b0, 2'b00, 16'd3};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,        2'b00, 1'b0, 32'h3456_12BB, 1'b1, 2'b01, 16'd3};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 2'b01, 16'd3};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,        2'b00, 1'b0, 32'h3456_12BB, 1'b1, 2'b01, 16'd3};
      vecs[12] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,        2'b00, 1'b0, 32'h0000_0000, 1'b1, 2'b01, 16'd3};

      reset = 1'b1;
      idle();
      repeat (2) @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         @(negedge clock);
         drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data, vecs[i].wbh, vecs[i].fh);
         #1;
         check($sformatf("v%0d_dmemout", i), bus.dmemout, vecs[i].exp_out);
         check($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_err_code", i), 32'(bus.err_code), 32'(vecs[i].exp_code));
         check($sformatf("v%0d_st_count", i), 32'(bus.st_count), 32'(vecs[i].exp_cnt));
      end

      // First fault address kept, then cleared
      @(negedge clock);
      idle();
      #1;
      check("err_addr_first", bus.err_addr, 32'h0000_0003);
      bus.err_clr = 1'b1;
      @(negedge clock);
      bus.err_clr = 1'b0;
      #1;
      check("clr_err", 32'(bus.err), 32'd0);
      check("clr_err_code", 32'(bus.err_code), 32'd0);
      check("clr_err_addr", bus.err_addr, 32'h0);

      // Clear and fault together while err is low: fault captured
      @(negedge clock);
      drive(1'b0, 1'b1, 32'h0000_0102, 32'h0, 2'b00, 1'b0);
      bus.err_clr = 1'b1;
      @(negedge clock);
      idle();
      #1;
      check("clr_cap_err", 32'(bus.err), 32'd1);
      check("clr_cap_code", 32'(bus.err_code), 32'd2);
      check("clr_cap_addr", bus.err_addr, 32'h0000_0102);
      bus.err_clr = 1'b1;
      @(negedge clock);
      bus.err_clr = 1'b0;

      // Read-during-write at the same address
      drive(1'b1, 1'b0, 32'h0000_0008, 32'h1111_1111, 2'b00, 1'b0);
      @(negedge clock);
      drive(1'b1, 1'b1, 32'h0000_0008, 32'h2222_2222, 2'b00, 1'b0);
      #1;
      check("rdw_old", bus.dmemout, 32'h1111_1111);
      @(negedge clock);
      drive(1'b0, 1'b1, 32'h0000_0008, 32'h0, 2'b00, 1'b0);
      #1;
      check("rdw_new", bus.dmemout, 32'h2222_2222);
      check("rdw_st_count", 32'(bus.st_count), 32'd5);

      // Reserved size with a load enable
      @(negedge clock);
      drive(1'b0, 1'b1, 32'h0000_0020, 32'h0, 2'b11, 1'b0);
      #1;
      check("rsvd_dmemout", bus.dmemout, 32'h0);
      @(negedge clock);
      drive(1'b0, 1'b1, 32'h0000_0008, 32'h0, 2'b00, 1'b0);
      #1;
      check("rsvd_err", 32'(bus.err), 32'd1);
      check("rsvd_code", 32'(bus.err_code), 32'd3);
      check("rsvd_addr", bus.err_addr, 32'h0000_0020);

      // Asynchronous reset in the middle of a store
      @(negedge clock);
      drive(1'b1, 1'b1, 32'h0000_0008, 32'h3333_3333, 2'b00, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_dmemout", bus.dmemout, 32'h0);
      check("arst_err", 32'(bus.err), 32'd0);
      check("arst_err_code", 32'(bus.err_code), 32'd0);
      check("arst_err_addr", bus.err_addr, 32'h0);
      check("arst_st_count", 32'(bus.st_count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      drive(1'b0, 1'b1, 32'h0000_0008, 32'h0, 2'b00, 1'b0);
      #1;
      check("arst_store_lost", bus.dmemout, 32'h0);
      check("arst_word4", 32'(bus.st_count), 32'd0);

      // Fault with neither enable is never recorded
      @(negedge clock);
      drive(1'b0, 1'b0, 32'h0000_0200, 32'h0, 2'b11, 1'b0);
      @(negedge clock);
      idle();
      #1;
      check("noena_err", 32'(bus.err), 32'd0);

      // Store counter saturation
      drive(1'b1, 1'b0, 32'h0000_000C, 32'h0000_00A5, 2'b00, 1'b0);
      repeat (65534) @(negedge clock);
      #1;
      check("sat_fffe", 32'(bus.st_count), 32'h0000_FFFE);
      repeat (2) @(negedge clock);
      #1;
      check("sat_ffff", 32'(bus.st_count), 32'h0000_FFFF);
      @(negedge clock);
      #1;
      check("sat_hold", 32'(bus.st_count), 32'h0000_FFFF);
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
